freq_meter_nch: RTL and testbench
=================================

# freq_meter_nch

Multi-channel, parametrised frequency meter. Counts synchronised rising edges on each of `N_CH` asynchronous inputs over a common gate window of `GATE_CYCLES` clocks, then publishes all channel results together with a one-cycle valid strobe. The display and readout logic consumes these results. This block replaces the single-channel, fixed-window, level-sampling counter with edge-accurate counting, saturation and overflow reporting.

## Interface
Parameters:
- `N_CH`, 4: number of independent input channels (1..16).
- `CNT_W`, 16: width of each per-channel edge count and result.
- `GATE_CYCLES`, 100000000: gate window length in clocks (1 s at 100 MHz); minimum 2.
- `GATE_W`, `$clog2(GATE_CYCLES)`: width of the gate counter.

Ports (one clock; reset is synchronous and active-high, and the clock and reset ports are named `CLK` and `RESET`):
- `CLK` in 1: system clock, 100 MHz.
- `RESET` in 1: synchronous, active-high reset.
- `EN` in 1: when low, the gate counter and all edge counters hold their values.
- `IN` in `N_CH`: asynchronous signal inputs; bit i is channel i.
- `freq` out `N_CH*CNT_W`: latched results; channel i occupies bits `[i*CNT_W +: CNT_W]`.
- `ovf` out `N_CH`: per-channel saturation flag for the latched window.
- `freq_valid` out 1: one-cycle pulse when `freq`/`ovf` update.
- `gate_pos` out `GATE_W`: current gate counter value, for debug.

## Operation
- Per channel: two-flop synchroniser `s0`, `s1`, then a previous-value register `p`.
  - `rise = s1 & ~p`.
- Gate counter `g` runs 0 .. `GATE_CYCLES-1` and wraps to 0 while `EN` is high.
- Non-terminal cycle (`g != GATE_CYCLES-1`, `EN` high): `cnt <= sat(cnt + rise)`.
- Terminal cycle (`g == GATE_CYCLES-1`, `EN` high):
  - `freq[i] <= sat(cnt + rise)`, so an edge in the terminal cycle belongs to the closing window.
  - `ovf[i] <=` saturation reached in this window.
  - `cnt <= 0`; `g <= 0`; `freq_valid <= 1`.
- Saturation: the count sticks at `2^CNT_W-1` and never wraps. The per-channel sticky `sat_flag` clears at window close.
- `EN` low: synchronisers keep sampling, so `p` tracks `s1` and edges during hold are lost rather than deferred. `g` and `cnt` hold, and `freq_valid` is 0.
- `RESET` high: `s0`, `s1`, `p`, `cnt`, `g`, `freq`, `ovf`, `freq_valid` all go to 0 on the next edge.
  - A reset mid-window discards the partial window; no result is published.
  - If `IN` is high at reset release, it counts as one rising edge in the first window.
- `RESET` takes priority over `EN` and over the terminal-cycle update.

## Timing
- A rising `IN` first sampled high by `s0` at edge k gives `rise` high during the cycle after edge k+1. It is added to `cnt` at edge k+2.
- `freq_valid` is high for exactly the single cycle after each terminal-cycle edge. Consecutive pulses are `GATE_CYCLES` clocks apart when `EN` stays high.
- `freq` and `ovf` change only on the edge that sets `freq_valid`, and are stable between pulses.
- The first `freq_valid` after reset occurs `GATE_CYCLES` enabled clocks after release.
- Maximum countable input rate: `CLK/2` (pulses must be high ≥1 and low ≥1 clock as seen by `s1`).

## Configuration
- `FREQ_METER_AVG_EN` defined:
  - Each channel keeps the last 4 window results in a shift register, zero after reset.
  - Published `freq[i] = (w0+w1+w2+w3) >> 2`. The sum is computed in `CNT_W+2` bits and truncated.
  - `ovf[i]` is the OR of the 4 windows' flags.
  - Output timing and `freq_valid` are unchanged.
- Not defined: `freq[i]` is the raw count of the single closing window. No history registers exist.

## Structure
- Package `freq_meter_pkg`:
  - default constants (`CLK_HZ = 100000000`, default `GATE_CYCLES`);
  - the `sat_inc` function (saturating add of a 1-bit increment to a `CNT_W` value);
  - the averaging depth constant (4).
- Sub-module `freq_edge_chan`, instantiated `N_CH` times in a generate loop, contains:
  - the synchroniser, edge detector, saturating counter and sticky flag;
  - in `FREQ_METER_AVG_EN` builds, the history and average;
  - inputs `CLK`, `RESET`, `EN`, `in`, `close`;
  - outputs `result`, `ovf`.
- The top level holds the gate counter, `close` generation and `freq_valid`.

## Test plan
All scenarios use `GATE_CYCLES=100`, `N_CH=2`, `CNT_W=8` unless stated.
- Square wave period 10 clocks on ch0, ch1 tied low → every `freq_valid` after the first window shows ch0 `freq=10`, `ovf=0`; ch1 `freq=0`; pulses exactly 100 clocks apart.
- `CNT_W=4`, 20 edges per window on ch0 → `freq=15`, `ovf=1`; next window with 5 edges → `freq=5`, `ovf=0`.
- Single edge timed so `rise` is high in the terminal cycle (`gate_pos=99`) → counted in the closing window (`freq=1`); next window `freq=0`.
- `RESET` asserted at `gate_pos=50` with 5 edges counted → no `freq_valid`, `freq=0`; the first `freq_valid` comes 100 clocks after release.
- `EN` low for 30 clocks mid-window while ch0 toggles → `gate_pos` frozen, edges during hold not counted, window stretched to 130 clocks.
- `FREQ_METER_AVG_EN`, windows of 8, 8, 8, 12 edges → published 2, 4, 6, 9.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module  : freq_meter_pkg
// Brief   : Shared constants and saturating-increment helper for freq_meter_nch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

  localparam int CLK_HZ          = 100000000;
  localparam int GATE_CYCLES_DEF = CLK_HZ;
  localparam int AVG_DEPTH       = 4;
  localparam int AVG_SHIFT       = 2;

  // Adds a 1-bit increment to a WIDTH-bit value, sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input int          width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (inc && (val != max_v)) ? (val + 32'd1) : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_edge_chan.sv
// ============================================================================
// Module  : freq_edge_chan
// Brief   : One channel: synchroniser, rising-edge detect, saturating window
//           counter with sticky overflow; optional 4-window average when
//           FREQ_METER_AVG_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_edge_chan
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             in,
  input  logic             close,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] C_MAX_CNT = '1;

  logic             s0_q, s1_q, p_q;
  logic             w_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q;
  logic             w_win_ovf;
  logic [CNT_W-1:0] result_q;
  logic             ovf_q;

  assign w_rise    = s1_q & ~p_q;
  assign cnt_d     = CNT_W'(sat_inc(32'(cnt_q), w_rise, CNT_W));
  assign w_win_ovf = sat_q | (cnt_d == C_MAX_CNT);

  // Synchroniser keeps sampling while EN is low so held edges are dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
      p_q   <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      s0_q <= in;
      s1_q <= s0_q;
      p_q  <= s1_q;
      if (EN) begin
        if (close) begin
          cnt_q <= '0;
          sat_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          if (cnt_d == C_MAX_CNT) sat_q <= 1'b1;
        end
      end
    end
  end

`ifdef FREQ_METER_AVG_EN
  logic [CNT_W-1:0]     hist_q [AVG_DEPTH-1];
  logic [AVG_DEPTH-2:0] hovf_q;
  logic [CNT_W+1:0]     w_sum;

  always_comb begin
    w_sum = {2'b00, cnt_d};
    for (int k = 0; k < AVG_DEPTH - 1; k++) w_sum = w_sum + {2'b00, hist_q[k]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < AVG_DEPTH - 1; k++) hist_q[k] <= '0;
      hovf_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (EN && close) begin
      hist_q[0] <= cnt_d;
      for (int k = 1; k < AVG_DEPTH - 1; k++) hist_q[k] <= hist_q[k-1];
      hovf_q   <= {hovf_q[AVG_DEPTH-3:0], w_win_ovf};
      result_q <= CNT_W'(w_sum >> AVG_SHIFT);
      ovf_q    <= w_win_ovf | (|hovf_q);
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (EN && close) begin
      result_q <= cnt_d;
      ovf_q    <= w_win_ovf;
    end
  end
`endif

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: rtl/freq_meter_nch.sv
// ============================================================================
// Module  : freq_meter_nch
// Brief   : N-channel edge-counting frequency meter with a shared gate window;
//           averaging over 4 windows is enabled by FREQ_METER_AVG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter_nch
  import freq_meter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int GATE_W      = $clog2(GATE_CYCLES)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic [N_CH-1:0]       IN,
  output logic [N_CH*CNT_W-1:0] freq,
  output logic [N_CH-1:0]       ovf,
  output logic                  freq_valid,
  output logic [GATE_W-1:0]     gate_pos
);

  localparam logic [GATE_W-1:0] C_GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0] g_q;
  logic              valid_q;
  logic              w_close;

  assign w_close = EN && (g_q == C_GATE_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      g_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= w_close;
      if (EN) g_q <= w_close ? '0 : g_q + GATE_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    freq_edge_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .CLK    (CLK),
      .RESET  (RESET),
      .EN     (EN),
      .in     (IN[i]),
      .close  (w_close),
      .result (freq[i*CNT_W +: CNT_W]),
      .ovf    (ovf[i])
    );
  end

  assign freq_valid = valid_q;
  assign gate_pos   = g_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter_nch.sv
// ============================================================================
// Module  : tb_freq_meter_nch
// Brief   : Bench for freq_meter_nch (N_CH=2, CNT_W=4, GATE_CYCLES=100);
//           honours FREQ_METER_AVG_EN for the expected values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter_nch;

  localparam int NC   = 2;
  localparam int CW   = 4;
  localparam int GC   = 100;
  localparam int GW   = $clog2(GC);
  localparam int MAXV = (1 << CW) - 1;
`ifdef FREQ_METER_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             EN = 1'b0;
  logic [NC-1:0]    IN = '0;
  logic [NC*CW-1:0] freq;
  logic [NC-1:0]    ovf;
  logic             freq_valid;
  logic [GW-1:0]    gate_pos;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  freq_meter_nch #(
    .N_CH        (NC),
    .CNT_W       (CW),
    .GATE_CYCLES (GC),
    .GATE_W      (GW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .IN         (IN),
    .freq       (freq),
    .ovf        (ovf),
    .freq_valid (freq_valid),
    .gate_pos   (gate_pos)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // An input rise seen in the sample stream at edge t is credited at edge t+2
  // (if enabled); reset treats the input history as low.
  int  m_cnt  [NC];
  int  m_freq [NC];
  bit  m_ovf  [NC];
  int  m_hist [NC][4];
  bit  m_hovf [NC][4];
  bit  m_prev [NC];
  bit  m_pa   [NC];
  bit  m_pb   [NC];
  int  m_g;
  bit  m_valid;
  bit  m_live = 1'b0;
  bit  m_close;
  int  m_cr, m_tot, m_sum;
  bit  m_or;

  always @(posedge CLK) begin
    cyc++;
    if (RESET === 1'b1) begin
      m_live  = 1'b1;
      m_g     = 0;
      m_valid = 1'b0;
      for (int c = 0; c < NC; c++) begin
        m_cnt[c] = 0; m_freq[c] = 0; m_ovf[c] = 1'b0;
        m_prev[c] = 1'b0; m_pa[c] = 1'b0; m_pb[c] = 1'b0;
        for (int k = 0; k < 4; k++) begin m_hist[c][k] = 0; m_hovf[c][k] = 1'b0; end
      end
    end else if (m_live) begin
      m_close = (EN === 1'b1) && (m_g == GC - 1);
      for (int c = 0; c < NC; c++) begin
        m_cr      = int'(m_pb[c]);
        m_pb[c]   = m_pa[c];
        m_pa[c]   = IN[c] & ~m_prev[c];
        m_prev[c] = IN[c];
        if (EN === 1'b1) begin
          m_tot = m_cnt[c] + m_cr;
          if (m_tot > MAXV) m_tot = MAXV;
          if (m_close) begin
            for (int k = 3; k > 0; k--) begin
              m_hist[c][k] = m_hist[c][k-1];
              m_hovf[c][k] = m_hovf[c][k-1];
            end
            m_hist[c][0] = m_tot;
            m_hovf[c][0] = (m_tot == MAXV);
            if (AVG) begin
              m_sum = 0; m_or = 1'b0;
              for (int k = 0; k < 4; k++) begin
                m_sum += m_hist[c][k];
                m_or  |= m_hovf[c][k];
              end
              m_freq[c] = (m_sum / 4) % (MAXV + 1);
              m_ovf[c]  = m_or;
            end else begin
              m_freq[c] = m_tot;
              m_ovf[c]  = (m_tot == MAXV);
            end
            m_cnt[c] = 0;
          end else begin
            m_cnt[c] = m_tot;
          end
        end
      end
      if (EN === 1'b1) begin
        m_valid = m_close;
        m_g     = m_close ? 0 : m_g + 1;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  logic [NC*CW-1:0] exp_freq;
  logic [NC-1:0]    exp_ovf;

  always @(negedge CLK) begin
    if (m_live) begin
      for (int c = 0; c < NC; c++) begin
        exp_freq[c*CW +: CW] = CW'(m_freq[c]);
        exp_ovf[c]           = m_ovf[c];
      end
      total++;
      if ({freq, ovf, freq_valid, gate_pos} !== {exp_freq, exp_ovf, m_valid, GW'(m_g)}) begin
        bad++;
        $display("FAIL model cyc=%0d freq=%h/%h ovf=%b/%b valid=%b/%b gate_pos=%0d/%0d (got/exp)",
                 cyc, freq, exp_freq, ovf, exp_ovf, freq_valid, m_valid, gate_pos, m_g);
      end
    end
  end

  // ---------------- publication log ----------------
  typedef struct {
    int            c;
    logic [CW-1:0] f0;
    logic [CW-1:0] f1;
    logic [NC-1:0] o;
  } pub_t;
  pub_t pubs[$];

  always @(negedge CLK) begin
    if (freq_valid === 1'b1) pubs.push_back('{cyc, freq[CW-1:0], freq[2*CW-1:CW], ovf});
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NC-1:0] i_v, input logic e_v, input logic r_v);
    @(negedge CLK);
    IN    = i_v;
    EN    = e_v;
    RESET = r_v;
  endtask

  task automatic do_reset();
    drive('0, 1'b1, 1'b1);
    drive('0, 1'b1, 1'b1);
    pubs.delete();
  endtask

  function automatic logic pulse(input int j, input int start, input int n, input int per);
    return (j >= start) && (j < start + n * per) && (((j - start) % per) < per / 2);
  endfunction

  // ---------------- scenarios ----------------
  int            rel;
  int            rate;
  logic [NC-1:0] cur_in;
  logic          en_r, rst_r;
  int            e6 [4];

  initial begin
    // S1: 10-clock square on ch0, ch1 low
    do_reset();
    for (int j = 1; j <= 550; j++) begin
      drive({1'b0, logic'((j - 1) % 10 < 5)}, 1'b1, 1'b0);
      if (j == 1) rel = cyc;
    end
    chk("s1_npubs", 32'(pubs.size() >= 5), 1);
    if (pubs.size() >= 5) begin
      chk("s1_first_at", pubs[0].c - rel, GC);
      chk("s1_f0_w3", pubs[3].f0, 10);
      chk("s1_f0_w4", pubs[4].f0, 10);
      chk("s1_f1_w4", pubs[4].f1, 0);
      chk("s1_ovf_w4", pubs[4].o, 0);
      chk("s1_spacing", pubs[4].c - pubs[3].c, GC);
    end

    // S2: 20 edges saturate a 4-bit count, then 5 edges
    do_reset();
    for (int j = 1; j <= 210; j++)
      drive({1'b0, pulse(j, 1, 20, 4) | pulse(j, 99, 5, 4)}, 1'b1, 1'b0);
    chk("s2_npubs", 32'(pubs.size() >= 2), 1);
    if (pubs.size() >= 2) begin
      chk("s2_sat_f", pubs[0].f0, AVG ? 3 : 15);
      chk("s2_sat_o", pubs[0].o, 1);
      chk("s2_next_f", pubs[1].f0, 5);
      chk("s2_next_o", pubs[1].o, AVG ? 1 : 0);
    end

    // S3: single rise landing in the terminal cycle
    do_reset();
    for (int j = 1; j <= 210; j++) drive({1'b0, logic'(j == 98)}, 1'b1, 1'b0);
    chk("s3_npubs", 32'(pubs.size() >= 2), 1);
    if (pubs.size() >= 2) begin
      chk("s3_term_f", pubs[0].f0, AVG ? 0 : 1);
      chk("s3_next_f", pubs[1].f0, 0);
    end

    // S4: reset mid-window discards partial count
    do_reset();
    for (int j = 1; j <= 50; j++) drive({1'b0, pulse(j, 1, 5, 4)}, 1'b1, 1'b0);
    chk("s4_pos_pre", gate_pos, 49);
    chk("s4_no_pub_pre", pubs.size(), 0);
    do_reset();
    for (int j = 1; j <= 110; j++) begin
      drive('0, 1'b1, 1'b0);
      if (j == 1) begin
        rel = cyc;
        chk("rst_freq", freq, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid", freq_valid, 0);
        chk("rst_pos", gate_pos, 0);
      end
    end
    chk("s4_npubs", pubs.size(), 1);
    if (pubs.size() >= 1) begin
      chk("s4_first_at", pubs[0].c - rel, GC);
      chk("s4_f0", pubs[0].f0, 0);
    end

    // S5: EN low for 30 clocks stretches window and drops edges
    do_reset();
    for (int j = 1; j <= 140; j++) begin
      drive({1'b0, pulse(j, 1, 20, 8)}, logic'(!(j >= 40 && j <= 69)), 1'b0);
      if (j == 1) rel = cyc;
      if (j == 60) chk("s5_frozen_pos", gate_pos, 39);
    end
    chk("s5_npubs", pubs.size(), 1);
    if (pubs.size() >= 1) begin
      chk("s5_stretch", pubs[0].c - rel, GC + 30);
      chk("s5_f0", pubs[0].f0, AVG ? 3 : 12);
    end

    // S6: windows of 8, 8, 8, 12 edges
    do_reset();
    for (int j = 1; j <= 405; j++)
      drive({1'b0, pulse(j, 1, 8, 8) | pulse(j, 99, 8, 8) | pulse(j, 199, 8, 8) | pulse(j, 299, 12, 8)},
            1'b1, 1'b0);
    if (AVG) e6 = '{2, 4, 6, 9};
    else     e6 = '{8, 8, 8, 12};
    chk("s6_npubs", 32'(pubs.size() >= 4), 1);
    if (pubs.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("s6_w%0d", k), pubs[k].f0, e6[k]);

    // Random phase: both channels, random toggle density, EN drops, resets
    do_reset();
    cur_in = '0;
    for (int seg = 0; seg < 15; seg++) begin
      rate = $urandom_range(1, 6);
      for (int k = 0; k < 200; k++) begin
        for (int c = 0; c < NC; c++)
          if ($urandom_range(0, rate - 1) == 0) cur_in[c] = ~cur_in[c];
        en_r  = ($urandom_range(0, 19) != 0);
        rst_r = ($urandom_range(0, 499) == 0);
        drive(cur_in, en_r, rst_r);
      end
    end
    drive('0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
